// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg
//   Shared types and constants for the 5-stage core pipeline control unit.
//   ctrl_state_e : control FSM states (RUN, REDIR_PEND)
//   REG_ADDR_W   : register index width
//   X0_IDX       : index of the hard-wired zero register
//   NOP_INSTR    : encoding the IF/ID register loads on a flush (addi x0,x0,0)
package pipe_ctrl_pkg;

  typedef enum logic {
    RUN        = 1'b0,
    REDIR_PEND = 1'b1
  } ctrl_state_e;

  localparam int REG_ADDR_W = 5;
  localparam int X0_IDX     = 0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/load_use_detect.sv
// load_use_detect
//   Purely combinational load-use hazard detector. Flags when the instruction
//   in ID reads a register that the load currently in EX will write.
//   Ports:
//     id_rs1, id_rs2           ID-stage source register indices
//     id_uses_rs1, id_uses_rs2 ID instruction actually reads rs1 / rs2
//     ex_rd                    EX-stage destination register index
//     ex_mem_read              EX instruction is a load
//     load_use                 hazard present this cycle
module load_use_detect #(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);
  import pipe_ctrl_pkg::*;

  logic rd_nonzero;
  logic rs1_hit;
  logic rs2_hit;

  // A load targeting x0 never produces a value, so it cannot cause a hazard.
  assign rd_nonzero = (ex_rd != REG_ADDR_W'(X0_IDX));
  assign rs1_hit    = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit    = id_uses_rs2 && (id_rs2 == ex_rd);
  assign load_use   = ex_mem_read && rd_nonzero && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Pipeline control unit for the 5-stage core. Each cycle it drives the PC,
//   IF/ID and ID/EX enables/flushes, resolving (in priority order) data-memory
//   freezes, taken-branch redirects, load-use hazards and fetch wait states.
//   A redirect that cannot be issued because fetch is not ready is held in
//   REDIR_PEND until imem_ready. Stall and redirect-flush counters are kept.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     id_rs1/id_rs2/id_uses_rs*    ID-stage operand usage
//     ex_rd, ex_mem_read           EX-stage load destination
//     ex_branch_taken/_target      EX-resolved redirect
//     imem_ready                   fetch interface accepts/returns this cycle
//     dmem_busy                    data memory stall, freezes the whole pipe
//     pc_write_en, if_id_write_en  register load enables
//     if_id_flush, id_ex_bubble    NOP insertion into IF/ID, ID/EX
//     pc_redirect(_target)         PC mux select and redirect address
//     stall_count, flush_count     performance counters (wrap at 2^CNT_W)
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = pipe_ctrl_pkg::REG_ADDR_W,
  parameter int XLEN       = 32,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic [XLEN-1:0]       ex_branch_target,
  input  logic                  imem_ready,
  input  logic                  dmem_busy,
  output logic                  pc_write_en,
  output logic                  if_id_write_en,
  output logic                  if_id_flush,
  output logic                  id_ex_bubble,
  output logic                  pc_redirect,
  output logic [XLEN-1:0]       pc_redirect_target,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);
  import pipe_ctrl_pkg::*;

  ctrl_state_e       state_reg;
  ctrl_state_e       state_next;
  logic [XLEN-1:0]   pend_target_reg;
  logic [XLEN-1:0]   pend_target_next;
  logic [CNT_W-1:0]  stall_count_reg;
  logic [CNT_W-1:0]  flush_count_reg;
  logic              redirect_flush; // flush caused by a redirect (not a fetch bubble)
  logic              load_use;

  load_use_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  always_comb begin
    pc_write_en      = 1'b0;
    if_id_write_en   = 1'b0;
    if_id_flush      = 1'b0;
    id_ex_bubble     = 1'b0;
    pc_redirect      = 1'b0;
    redirect_flush   = 1'b0;
    state_next       = state_reg;
    pend_target_next = pend_target_reg;

    if (!rst) begin
      unique case (state_reg)
        RUN: begin
          if (dmem_busy) begin
            // Whole pipe frozen; a taken branch in EX is re-presented later.
          end else if (ex_branch_taken && imem_ready) begin
            pc_redirect    = 1'b1;
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            redirect_flush = 1'b1;
          end else if (ex_branch_taken) begin
            // Fetch cannot take the redirect yet: squash now, remember target.
            if_id_flush      = 1'b1;
            id_ex_bubble     = 1'b1;
            redirect_flush   = 1'b1;
            pend_target_next = ex_branch_target;
            state_next       = REDIR_PEND;
          end else if (load_use) begin
            // Single bubble: the load has left EX by the next cycle.
            id_ex_bubble = 1'b1;
          end else if (!imem_ready) begin
            // Fetch wait state: IF/ID takes a NOP, PC holds.
            if_id_write_en = 1'b1;
            if_id_flush    = 1'b1;
          end else begin
            pc_write_en    = 1'b1;
            if_id_write_en = 1'b1;
          end
        end

        REDIR_PEND: begin
          // EX holds a bubble here, so branch and load-use inputs are ignored.
          if (dmem_busy) begin
          end else if (imem_ready) begin
            pc_redirect    = 1'b1;
            pc_write_en    = 1'b1;
            if_id_flush    = 1'b1;
            redirect_flush = 1'b1;
            state_next     = RUN;
          end else begin
            if_id_flush    = 1'b1;
            id_ex_bubble   = 1'b1;
            redirect_flush = 1'b1;
          end
        end

        default: state_next = RUN;
      endcase
    end
  end

  always_comb begin
    if (rst) begin
      pc_redirect_target = '0;
    end else if (state_reg == REDIR_PEND) begin
      pc_redirect_target = pend_target_reg;
    end else begin
      pc_redirect_target = ex_branch_target;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= RUN;
      pend_target_reg <= '0;
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else begin
      state_reg       <= state_next;
      pend_target_reg <= pend_target_next;
      if (!pc_write_en) begin
        stall_count_reg <= stall_count_reg + CNT_W'(1);
      end
      if (redirect_flush) begin
        flush_count_reg <= flush_count_reg + CNT_W'(1);
      end
    end
  end

  assign stall_count = stall_count_reg;
  assign flush_count = flush_count_reg;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random stimulus, expected responses pushed to a scoreboard queue and checked
// by an independent monitor on the falling edge. A second instance with a
// 4-bit counter width exercises counter wrap.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_uses_rs1 = 0, id_uses_rs2 = 0, ex_mem_read = 0;
  logic        ex_branch_taken = 0, imem_ready = 0, dmem_busy = 0;
  logic [31:0] ex_branch_target = '0;

  logic        pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, pc_redirect;
  logic [31:0] pc_redirect_target, stall_count, flush_count;

  logic        w4_pc_we, w4_ifid_we, w4_flush, w4_bubble, w4_redir;
  logic [31:0] w4_target;
  logic [3:0]  w4_stall_count, w4_flush_count;

  always #5 clk = ~clk;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .pc_redirect(pc_redirect), .pc_redirect_target(pc_redirect_target),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  pipe_hazard_ctrl #(.CNT_W(4)) dut_w4 (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken), .ex_branch_target(ex_branch_target),
    .imem_ready(imem_ready), .dmem_busy(dmem_busy),
    .pc_write_en(w4_pc_we), .if_id_write_en(w4_ifid_we),
    .if_id_flush(w4_flush), .id_ex_bubble(w4_bubble),
    .pc_redirect(w4_redir), .pc_redirect_target(w4_target),
    .stall_count(w4_stall_count), .flush_count(w4_flush_count)
  );

  typedef struct {
    logic        pc_we, ifid_we, flush, bubble, redir;
    logic [31:0] tgt, stall, flushc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   txn   = 0;

  // Reference model state: is a redirect owed to fetch, and the counters.
  bit          m_pend  = 0;
  logic [31:0] m_ptgt  = '0;
  logic [31:0] m_stall = '0;
  logic [31:0] m_flush = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL txn %0d %s: got %h expected %h", txn, name, act, expv);
    end
  endtask

  // Monitor: one transaction per cycle, sampled mid-cycle.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      $display("[TB] txn %0d pc_we=%b ifid_we=%b flush=%b bubble=%b redir=%b tgt=%h stall=%0d flushc=%0d",
               txn, pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, pc_redirect,
               pc_redirect_target, stall_count, flush_count);
      chk("pc_write_en",    {31'b0, pc_write_en},    {31'b0, e.pc_we});
      chk("if_id_write_en", {31'b0, if_id_write_en}, {31'b0, e.ifid_we});
      chk("if_id_flush",    {31'b0, if_id_flush},    {31'b0, e.flush});
      chk("id_ex_bubble",   {31'b0, id_ex_bubble},   {31'b0, e.bubble});
      chk("pc_redirect",    {31'b0, pc_redirect},    {31'b0, e.redir});
      chk("target",         pc_redirect_target,      e.tgt);
      chk("stall_count",    stall_count,             e.stall);
      chk("flush_count",    flush_count,             e.flushc);
      chk("stall_count_w4", {28'b0, w4_stall_count}, {28'b0, e.stall[3:0]});
      chk("flush_count_w4", {28'b0, w4_flush_count}, {28'b0, e.flushc[3:0]});
      txn++;
    end
  end

  // Apply one cycle of inputs, predict the response from the behavioural rules.
  task automatic step(input bit r, input logic [4:0] rs1, input logic [4:0] rs2,
                      input bit u1, input bit u2, input logic [4:0] exrd, input bit mr,
                      input bit bt, input logic [31:0] tg, input bit ir, input bit db);
    exp_t e;
    bit   lu;
    bit   redir_fl;
    rst = r; id_rs1 = rs1; id_rs2 = rs2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    ex_rd = exrd; ex_mem_read = mr; ex_branch_taken = bt; ex_branch_target = tg;
    imem_ready = ir; dmem_busy = db;

    e.pc_we = 0; e.ifid_we = 0; e.flush = 0; e.bubble = 0; e.redir = 0;
    e.stall = m_stall; e.flushc = m_flush;
    redir_fl = 0;
    if (r) begin
      e.tgt = '0;
      m_pend = 0; m_ptgt = '0; m_stall = '0; m_flush = '0;
    end else begin
      lu = mr && (exrd != 0) && ((u1 && rs1 == exrd) || (u2 && rs2 == exrd));
      e.tgt = m_pend ? m_ptgt : tg;
      if (db) begin
      end else if (m_pend) begin
        redir_fl = 1; e.flush = 1;
        if (ir) begin e.redir = 1; e.pc_we = 1; m_pend = 0; end
        else    e.bubble = 1;
      end else if (bt) begin
        redir_fl = 1; e.flush = 1; e.bubble = 1;
        if (ir) begin e.redir = 1; e.pc_we = 1; e.ifid_we = 1; end
        else begin m_pend = 1; m_ptgt = tg; end
      end else if (lu) begin
        e.bubble = 1;
      end else if (!ir) begin
        e.ifid_we = 1; e.flush = 1;
      end else begin
        e.pc_we = 1; e.ifid_we = 1;
      end
      if (!e.pc_we) m_stall = m_stall + 1;
      if (redir_fl) m_flush = m_flush + 1;
    end
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic idle();  step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0); endtask
  task automatic reset(); step(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0); endtask

  initial begin
    // Pre-reset so counters are defined before the scoreboard starts.
    repeat (2) @(posedge clk);
    #1;
    reset(); reset();
    idle();
    // Load-use on rs2, then the load has left EX.
    step(0, 3, 5, 1, 1, 5, 1, 0, 32'h0, 1, 0);
    idle();
    // Load to x0: no hazard.
    step(0, 0, 0, 1, 1, 0, 1, 0, 32'h0, 1, 0);
    // Taken branch with fetch ready.
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0100, 1, 0);
    idle();
    // Pending redirect to 0x200: fetch not ready for 3 cycles.
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0200, 0, 0);
    step(0, 1, 1, 1, 0, 1, 1, 1, 32'h0000_0ABC, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0DEF, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0444, 1, 0);
    idle();
    // dmem_busy dominates branch and load-use; then branch taken.
    step(0, 7, 0, 1, 0, 7, 1, 1, 32'h0000_0300, 1, 1);
    step(0, 7, 0, 1, 0, 7, 1, 1, 32'h0000_0300, 1, 1);
    step(0, 7, 0, 1, 0, 7, 1, 1, 32'h0000_0300, 1, 0);
    // Freeze while pending, then reset drops the pending redirect.
    step(0, 0, 0, 0, 0, 0, 0, 1, 32'h0000_0400, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 1);
    reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0000_0500, 1, 0);
    // Counter wrap on the 4-bit instance: 17 stall cycles.
    reset();
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
    idle();
    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      step($urandom_range(0, 99) == 0,
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
           5'($urandom_range(0, 3)), $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0, $urandom,
           $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
    end
    // Bounded drain of the scoreboard.
    repeat (3) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
